// File: rtl/td4e_pkg.sv
// Shared widths and FSM state type for the TD4E fetch unit.
// Used by td4e_fetch_unit and td4e_pc.
package td4e_pkg;

    localparam int unsigned INSTR_W = 8;
    localparam int unsigned OPC_W   = 4;
    localparam int unsigned IMM_W   = 4;
    localparam int unsigned PC_W    = 4;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StExec,
        StHalt
    } fetch_state_e;

endpackage

// File: rtl/td4e_pc.sv
// TD4E program counter: synchronous reset, increments or loads a jump target when enabled.
// The increment wraps modulo 2**PC_W.
module td4e_pc
    import td4e_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            load_n,
    input  logic [PC_W-1:0] d,
    output logic [PC_W-1:0] q
);

    logic [PC_W-1:0] q_q;
    logic [PC_W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = load_n ? q_q + PC_W'(1) : d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= RESET_PC;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/td4e_fetch_unit.sv
// TD4E fetch/execute sequencer: ROM handshake, instruction register, carry flag, halt control.
// Optional TD4E_SINGLE_STEP_EN adds step_mode/step inputs for single-instruction stepping.
module td4e_fetch_unit
    import td4e_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 4'h0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               mem_req,
    output logic [PC_W-1:0]    mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [OPC_W-1:0]   opcode,
    output logic [IMM_W-1:0]   imm,
    input  logic               pc_load_n,
    input  logic               carry_in,
    output logic               carry_q,
    output logic               exec_en,
    input  logic               halt,
`ifdef TD4E_SINGLE_STEP_EN
    input  logic               step_mode,
    input  logic               step,
`endif
    output logic [PC_W-1:0]    pc
);

    fetch_state_e       state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               carry_d;
    logic               single_step;
    logic               step_go;

`ifdef TD4E_SINGLE_STEP_EN
    assign single_step = step_mode;
    assign step_go     = step;
`else
    assign single_step = 1'b0;
    assign step_go     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ir_q    <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            carry_q <= carry_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  state_d = StFetch;
            StFetch: state_d = mem_ack ? StExec : StFetch;
            StExec:  state_d = (halt || single_step) ? StHalt : StFetch;
            StHalt:  state_d = (!halt || step_go) ? StFetch : StHalt;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_req = (state_q == StFetch);
        exec_en = (state_q == StExec);
        // IR only captures in FETCH, so stray acks elsewhere are ignored.
        ir_d    = (mem_req && mem_ack) ? mem_rdata : ir_q;
        carry_d = exec_en ? carry_in : carry_q;
    end

    td4e_pc #(
        .RESET_PC(RESET_PC)
    ) u_pc (
        .clk   (clk),
        .rst   (rst),
        .en    (exec_en),
        .load_n(pc_load_n),
        .d     (imm),
        .q     (pc)
    );

    assign mem_addr = pc;
    assign opcode   = ir_q[INSTR_W-1:IMM_W];
    assign imm      = ir_q[IMM_W-1:0];

endmodule

// File: tb/tb_td4e_fetch_unit.sv
// Directed testbench for td4e_fetch_unit with a small wait-state ROM model.
// Define TD4E_SINGLE_STEP_EN to also exercise the single-step ports.
module tb_td4e_fetch_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       mem_req;
    logic [3:0] mem_addr;
    logic       mem_ack;
    logic [7:0] mem_rdata;
    logic [3:0] opcode;
    logic [3:0] imm;
    logic       pc_load_n;
    logic       carry_in;
    logic       carry_q;
    logic       exec_en;
    logic       halt;
    logic       step_mode;
    logic       step;
    logic [3:0] pc;

    logic [7:0] rom [16];
    int         wait_cycles;
    int         wait_cnt;
    logic       force_ack;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    td4e_fetch_unit #(
        .RESET_PC(4'h0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .opcode   (opcode),
        .imm      (imm),
        .pc_load_n(pc_load_n),
        .carry_in (carry_in),
        .carry_q  (carry_q),
        .exec_en  (exec_en),
        .halt     (halt),
`ifdef TD4E_SINGLE_STEP_EN
        .step_mode(step_mode),
        .step     (step),
`endif
        .pc       (pc)
    );

    // ROM answers after wait_cycles stalled request cycles; force_ack injects stray acks.
    always_comb begin
        mem_rdata = rom[mem_addr];
        mem_ack   = force_ack || (mem_req && (wait_cnt == wait_cycles));
    end

    always_ff @(posedge clk) begin
        if (!mem_req || mem_ack) wait_cnt <= 0;
        else                     wait_cnt <= wait_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rom[0] = 8'h35;
        rst = 1'b1;
        tick();
        tick();
        n_cmp++; if (pc !== 4'h0) begin n_err++; $display("FAIL rst_pc: got %h want 0", pc); end
        n_cmp++; if (opcode !== 4'h0) begin n_err++; $display("FAIL rst_opc: got %h want 0", opcode); end
        n_cmp++; if (imm !== 4'h0) begin n_err++; $display("FAIL rst_imm: got %h want 0", imm); end
        n_cmp++; if (carry_q !== 1'b0) begin n_err++; $display("FAIL rst_carry: got %b want 0", carry_q); end
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", mem_req); end
        n_cmp++; if (exec_en !== 1'b0) begin n_err++; $display("FAIL rst_exec: got %b want 0", exec_en); end
        rst = 1'b0;
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL idle_req: got %b want 0", mem_req); end
        tick();
        n_cmp++; if ({mem_req, mem_addr} !== 5'b1_0000) begin
            n_err++; $display("FAIL first_fetch: got req=%b addr=%h want req=1 addr=0", mem_req, mem_addr);
        end
        tick();
        n_cmp++; if ({exec_en, opcode, imm, mem_req} !== 10'b1_0011_0101_0) begin
            n_err++; $display("FAIL first_exec: got en=%b opc=%h imm=%h req=%b want 1/3/5/0",
                              exec_en, opcode, imm, mem_req);
        end
        tick();
        n_cmp++; if ({pc, exec_en} !== 5'b0001_0) begin
            n_err++; $display("FAIL first_pc: got pc=%h en=%b want 1/0", pc, exec_en);
        end
    endtask

    task automatic test_wait_states();
        int cnt;
        rom[0] = 8'h35;
        rom[1] = 8'h47;
        wait_cycles = 3;
        do_reset();
        tick();
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if ({mem_req, mem_addr, exec_en} !== 6'b1_0000_0) begin
                n_err++; $display("FAIL wait_hold%0d: got req=%b addr=%h en=%b want 1/0/0",
                                  k, mem_req, mem_addr, exec_en);
            end
            tick();
        end
        n_cmp++; if ({exec_en, opcode} !== 5'b1_0011) begin
            n_err++; $display("FAIL wait_exec: got en=%b opc=%h want 1/3", exec_en, opcode);
        end
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (exec_en === 1'b1) cnt++;
        end
        n_cmp++; if (cnt !== 1) begin n_err++; $display("FAIL wait_one_exec: got %0d want 1", cnt); end
        wait_cycles = 0;
    endtask

    task automatic test_pc_wrap_and_load();
        rom[0]  = 8'hBF;
        rom[15] = 8'h29;
        do_reset();
        tick();
        pc_load_n = 1'b0;
        tick();
        tick();
        n_cmp++; if (pc !== 4'hF) begin n_err++; $display("FAIL jump_f: got %h want f", pc); end
        pc_load_n = 1'b1;
        tick();
        tick();
        n_cmp++; if (pc !== 4'h0) begin n_err++; $display("FAIL wrap: got %h want 0", pc); end
        rom[0] = 8'h69;
        tick();
        n_cmp++; if (imm !== 4'h9) begin n_err++; $display("FAIL load_imm: got %h want 9", imm); end
        pc_load_n = 1'b0;
        tick();
        n_cmp++; if (pc !== 4'h9) begin n_err++; $display("FAIL jump_9: got %h want 9", pc); end
        pc_load_n = 1'b1;
    endtask

    task automatic test_carry();
        rom[0] = 8'h35;
        rom[1] = 8'h47;
        do_reset();
        tick();
        carry_in = 1'b1;
        tick();
        n_cmp++; if (carry_q !== 1'b0) begin n_err++; $display("FAIL carry_fetch: got %b want 0", carry_q); end
        tick();
        n_cmp++; if (carry_q !== 1'b1) begin n_err++; $display("FAIL carry_load: got %b want 1", carry_q); end
        carry_in = 1'b0;
        wait_cycles = 2;
        tick();
        tick();
        n_cmp++; if (carry_q !== 1'b1) begin n_err++; $display("FAIL carry_hold: got %b want 1", carry_q); end
        tick();
        n_cmp++; if ({exec_en, carry_q} !== 2'b11) begin
            n_err++; $display("FAIL carry_exec: got en=%b c=%b want 1/1", exec_en, carry_q);
        end
        tick();
        n_cmp++; if (carry_q !== 1'b0) begin n_err++; $display("FAIL carry_clear: got %b want 0", carry_q); end
        wait_cycles = 0;
    endtask

    task automatic test_halt();
        rom[0] = 8'h35;
        rom[1] = 8'h47;
        do_reset();
        tick();
        halt = 1'b1;
        tick();
        tick();
        force_ack = 1'b1;
        for (int k = 0; k < 5; k++) begin
            n_cmp++; if ({mem_req, exec_en, pc, opcode} !== 10'b0_0_0001_0011) begin
                n_err++; $display("FAIL halt_hold%0d: got req=%b en=%b pc=%h opc=%h want 0/0/1/3",
                                  k, mem_req, exec_en, pc, opcode);
            end
            tick();
        end
        force_ack = 1'b0;
        halt = 1'b0;
        tick();
        n_cmp++; if ({mem_req, mem_addr} !== 5'b1_0001) begin
            n_err++; $display("FAIL halt_resume: got req=%b addr=%h want 1/1", mem_req, mem_addr);
        end
    endtask

    task automatic test_back_to_back();
        int cnt;
        for (int i = 0; i < 16; i++) rom[i] = 8'h10;
        do_reset();
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (exec_en === 1'b1) cnt++;
        end
        n_cmp++; if (cnt !== 5) begin n_err++; $display("FAIL b2b_rate: got %0d want 5", cnt); end
        n_cmp++; if (pc !== 4'h4) begin n_err++; $display("FAIL b2b_pc: got %h want 4", pc); end
    endtask

    task automatic test_reset_override();
        rom[0] = 8'h35;
        rom[1] = 8'hEE;
        do_reset();
        tick();
        carry_in = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        n_cmp++; if ({opcode, imm, pc, carry_q, mem_req, exec_en} !== 15'h0) begin
            n_err++; $display("FAIL rst_fetch: got opc=%h imm=%h pc=%h c=%b req=%b en=%b want all 0",
                              opcode, imm, pc, carry_q, mem_req, exec_en);
        end
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        n_cmp++; if ({opcode, pc, carry_q, exec_en} !== 10'h0) begin
            n_err++; $display("FAIL rst_exec: got opc=%h pc=%h c=%b en=%b want all 0",
                              opcode, pc, carry_q, exec_en);
        end
        rst = 1'b0;
        carry_in = 1'b0;
    endtask

`ifdef TD4E_SINGLE_STEP_EN
    task automatic test_single_step();
        int cnt;
        for (int i = 0; i < 16; i++) rom[i] = 8'h10;
        step_mode = 1'b1;
        halt = 1'b1;
        do_reset();
        tick();
        tick();
        tick();
        n_cmp++; if ({mem_req, exec_en, pc} !== 6'b0_0_0001) begin
            n_err++; $display("FAIL step_halt: got req=%b en=%b pc=%h want 0/0/1", mem_req, exec_en, pc);
        end
        for (int s = 0; s < 2; s++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            cnt = 0;
            for (int k = 0; k < 5; k++) begin
                if (exec_en === 1'b1) cnt++;
                tick();
            end
            n_cmp++; if (cnt !== 1) begin n_err++; $display("FAIL step_once%0d: got %0d want 1", s, cnt); end
        end
        n_cmp++; if (pc !== 4'h3) begin n_err++; $display("FAIL step_pc: got %h want 3", pc); end
        step_mode = 1'b0;
        halt = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b1;
        pc_load_n = 1'b1;
        carry_in = 1'b0;
        halt = 1'b0;
        step_mode = 1'b0;
        step = 1'b0;
        force_ack = 1'b0;
        wait_cycles = 0;
        for (int i = 0; i < 16; i++) rom[i] = 8'h10;
        test_reset();
        test_wait_states();
        test_pc_wrap_and_load();
        test_carry();
        test_halt();
        test_back_to_back();
        test_reset_override();
`ifdef TD4E_SINGLE_STEP_EN
        test_single_step();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/td4e_fetch_unit.md
TD4E_FETCH_UNIT -- requirements
Module: td4e_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 4'h0: PC value loaded on reset.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 mem_req  output  1  program-ROM read request.
REQ-006 mem_addr  output  4  ROM address; equals pc while mem_req=1.
REQ-007 mem_ack  input  1  read complete; mem_rdata valid this cycle.
REQ-008 mem_rdata  input  8  instruction word, opcode [7:4], immediate [3:0].
REQ-009 opcode  output  4  IR[7:4]; drives decoder instr.
REQ-010 imm  output  4  IR[3:0]; immediate to datapath and jump target.
REQ-011 pc_load_n  input  1  active-low PC load from decoder sel_PC.
REQ-012 carry_in  input  1  ALU carry of the executing instruction.
REQ-013 carry_q  output  1  registered carry flag; drives decoder c.
REQ-014 exec_en  output  1  one-cycle commit strobe for datapath registers.
REQ-015 halt  input  1  level request to stop after the current instruction.
REQ-016 pc  output  4  current program counter.

Function
REQ-017 The FSM SHALL have states IDLE, FETCH, EXEC and HALT.
REQ-018 IDLE SHALL go to FETCH unconditionally on the next cycle.
REQ-019 In FETCH, mem_req SHALL be 1 and mem_addr SHALL equal pc; both held stable until mem_ack.
REQ-020 FETCH with mem_ack=1 SHALL load IR from mem_rdata and go to EXEC; without mem_ack it SHALL stay in FETCH.
REQ-021 mem_req SHALL be 0 in IDLE, EXEC and HALT; mem_ack outside FETCH SHALL be ignored.
REQ-022 In EXEC, exec_en SHALL be 1 for exactly that cycle and 0 in every other state.
REQ-023 At the end of EXEC, pc SHALL load imm if pc_load_n=0, otherwise pc+1 modulo 16 (4'hF wraps to 4'h0).
REQ-024 At the end of EXEC, carry_q SHALL load carry_in; carry_q SHALL not change in any other state.
REQ-025 After EXEC the FSM SHALL enter HALT if halt=1, otherwise FETCH.
REQ-026 HALT SHALL return to FETCH in the first cycle halt=0 and SHALL not change pc, IR or carry_q.
REQ-027 With zero-wait ROM (mem_ack in the first FETCH cycle), throughput SHALL be one instruction per 2 cycles.
REQ-028 opcode and imm SHALL remain stable from IR load until the next IR load.

Reset
REQ-029 While rst=1, state=IDLE, pc=RESET_PC, IR=8'h00, carry_q=0, mem_req=0, exec_en=0.
REQ-030 rst SHALL override all other inputs, including mid-fetch with mem_ack=1 and during EXEC; no IR, PC or carry update happens in that cycle.
REQ-031 The first mem_req SHALL appear in the second cycle after rst deasserts (IDLE, then FETCH).

Configuration
REQ-032 Macro TD4E_SINGLE_STEP_EN SHALL add inputs step_mode (1 bit) and step (1 bit).
REQ-033 With TD4E_SINGLE_STEP_EN defined, step_mode=1 SHALL force HALT after every EXEC.
REQ-034 With TD4E_SINGLE_STEP_EN defined, HALT SHALL exit to FETCH on step=1, even if halt=1.
REQ-035 Without TD4E_SINGLE_STEP_EN, the ports SHALL be absent and behaviour SHALL be as step_mode=0.

Structure
REQ-036 Package td4e_pkg SHALL hold the FSM state enum, INSTR_W=8, OPC_W=4, IMM_W=4 and PC_W=4.
REQ-037 The PC register, increment and load mux SHALL be a sub-module td4e_pc (inputs: clk, rst, en, load_n, d; output: q).
REQ-038 The FSM, IR, carry flag and memory handshake SHALL remain in td4e_fetch_unit.

Verification
REQ-039 Zero-wait ROM holding 8'h35 at address 0 -> after reset: mem_req in cycle 2, opcode=4'h3, imm=4'h5, exec_en pulse in cycle 3, pc=1.
REQ-040 mem_ack delayed 3 cycles -> mem_req and mem_addr stable throughout, exactly one exec_en per instruction.
REQ-041 pc=4'hF, pc_load_n=1 at EXEC -> pc=4'h0; pc_load_n=0 with imm=4'h9 -> pc=4'h9.
REQ-042 carry_in=1 during EXEC, then carry_in=0 outside EXEC -> carry_q=1 and held until the next EXEC.
REQ-043 halt=1 across EXEC for 5 cycles -> HALT, mem_req=0, pc frozen; halt=0 -> FETCH of the next pc.
REQ-044 rst asserted in a cycle with mem_ack=1 -> IR=8'h00, pc=RESET_PC, no exec_en; with TD4E_SINGLE_STEP_EN and step_mode=1, each step pulse -> exactly one exec_en.
